// File: rtl/proc_core_if.sv
// proc_core_if: control strobes and observation outputs of the single-bus processor datapath
// master: control unit (drives strobes, observes bus/pc/ir/con)
// slave : proc_core (consumes strobes, drives bus/pc/ir/con)
interface proc_core_if;
    logic        pcout, zlowout, zhighout, mdrout, rout, baout, cout;
    logic        pcin, irin, marin, mdrin, yin, zin, rin, conin;
    logic        gra, grb, grc;
    logic        mem_read, mem_write;
    logic        op_inc, op_add, op_sub, op_and, op_or, op_mul, op_neg, op_not;
    logic        branch;
    logic [31:0] bus, pc, ir;
    logic        con;

    modport master (
        output pcout, zlowout, zhighout, mdrout, rout, baout, cout,
        output pcin, irin, marin, mdrin, yin, zin, rin, conin,
        output gra, grb, grc, mem_read, mem_write,
        output op_inc, op_add, op_sub, op_and, op_or, op_mul, op_neg, op_not, branch,
        input  bus, pc, ir, con
    );

    modport slave (
        input  pcout, zlowout, zhighout, mdrout, rout, baout, cout,
        input  pcin, irin, marin, mdrin, yin, zin, rin, conin,
        input  gra, grb, grc, mem_read, mem_write,
        input  op_inc, op_add, op_sub, op_and, op_or, op_mul, op_neg, op_not, branch,
        output bus, pc, ir, con
    );
endinterface

// File: rtl/proc_core.sv
// proc_core: single-bus 32-bit datapath (R0-R15, PC, IR, MAR, MDR, Y, 64-bit Z, CON, ALU, memory)
module proc_core #(
  parameter int MEM_WORDS = 512
) (
  input logic        clk,
  input logic        rst,
  proc_core_if.slave cb
);
  localparam int AW = $clog2(MEM_WORDS);
  logic [31:0]   pc_q, ir_q, mdr_q, y_q;
  logic [AW-1:0] mar_q;
  logic [63:0]   z_q;
  logic          con_q;
  logic [31:0]   r_q [16];
  logic [31:0]   mem [MEM_WORDS] = '{default: '0};
  logic [3:0]    sel;
  logic [31:0]   c_ext, bus, mem_rd;
  logic [63:0]   prod, alu_d;
  logic          con_d, pc_ld, mdr_ld;
  always_comb begin
    sel    = (cb.gra ? ir_q[26:23] : 4'd0) | (cb.grb ? ir_q[22:19] : 4'd0) | (cb.grc ? ir_q[18:15] : 4'd0);
    c_ext  = {{13{ir_q[18]}}, ir_q[18:0]};
    mem_rd = mem[mar_q];
    bus    = cb.mdrout   ? mdr_q :
             cb.zlowout  ? z_q[31:0] :
             cb.zhighout ? z_q[63:32] :
             cb.pcout    ? pc_q :
             cb.cout     ? c_ext :
             cb.rout     ? r_q[sel] :
             cb.baout    ? (sel == 4'd0 ? 32'd0 : r_q[sel]) : 32'd0;
    prod   = {{32{y_q[31]}}, y_q} * {{32{bus[31]}}, bus};
    alu_d  = cb.op_inc ? {32'd0, bus + 32'd1} :
             cb.op_add ? {32'd0, y_q + bus} :
             cb.op_sub ? {32'd0, y_q - bus} :
             cb.op_and ? {32'd0, y_q & bus} :
             cb.op_or  ? {32'd0, y_q | bus} :
             cb.op_mul ? prod :
             cb.op_neg ? {32'd0, -bus} :
             cb.op_not ? {32'd0, ~bus} : 64'd0;
    con_d  = ir_q[20:19] == 2'b00 ? (bus == 32'd0) :
             ir_q[20:19] == 2'b01 ? (bus != 32'd0) :
             ir_q[20:19] == 2'b10 ? ~bus[31] : bus[31];
    pc_ld  = cb.pcin | (cb.branch & con_q);
    mdr_ld = cb.mdrin & ~(cb.mem_read & cb.mem_write);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
      con_q <= 1'b0;
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
    end else begin
      if (pc_ld)    pc_q  <= bus;
      if (cb.irin)  ir_q  <= bus;
      if (cb.marin) mar_q <= bus[AW-1:0];
      if (mdr_ld)   mdr_q <= cb.mem_read ? mem_rd : bus;
      if (cb.yin)   y_q   <= bus;
      if (cb.zin)   z_q   <= alu_d;
      if (cb.rin)   r_q[sel] <= bus;
      if (cb.conin) con_q <= con_d;
    end
  end
  always_ff @(posedge clk) begin
    if (cb.mem_write) mem[mar_q] <= mdr_q;
  end
  assign cb.bus = bus;
  assign cb.pc  = pc_q;
  assign cb.ir  = ir_q;
  assign cb.con = con_q;
endmodule

// File: tb/tb_proc_core.sv
// tb_proc_core: self-checking bench for proc_core (directed tables plus randomized ALU/branch runs)
module tb_proc_core;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ctl;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mpc;

    localparam logic [31:0] PCOUT = 32'd1 << 0,  ZLOWOUT = 32'd1 << 1,  ZHIGHOUT = 32'd1 << 2;
    localparam logic [31:0] MDROUT = 32'd1 << 3, ROUT = 32'd1 << 4,     BAOUT = 32'd1 << 5;
    localparam logic [31:0] COUT = 32'd1 << 6,   PCIN = 32'd1 << 7,     IRIN = 32'd1 << 8;
    localparam logic [31:0] MARIN = 32'd1 << 9,  MDRIN = 32'd1 << 10,   YIN = 32'd1 << 11;
    localparam logic [31:0] ZIN = 32'd1 << 12,   RIN = 32'd1 << 13,     CONIN = 32'd1 << 14;
    localparam logic [31:0] GRA = 32'd1 << 15,   GRB = 32'd1 << 16,     GRC = 32'd1 << 17;
    localparam logic [31:0] READ = 32'd1 << 18,  WRITE = 32'd1 << 19,   INC = 32'd1 << 20;
    localparam logic [31:0] ADD = 32'd1 << 21,   SUB = 32'd1 << 22,     AND_ = 32'd1 << 23;
    localparam logic [31:0] OR_ = 32'd1 << 24,   MUL = 32'd1 << 25,     NEG = 32'd1 << 26;
    localparam logic [31:0] NOT_ = 32'd1 << 27,  BRANCH = 32'd1 << 28;

    proc_core_if ifc ();
    proc_core dut (.clk(clk), .rst(rst), .cb(ifc));

    assign ifc.pcout = ctl[0];      assign ifc.zlowout = ctl[1];   assign ifc.zhighout = ctl[2];
    assign ifc.mdrout = ctl[3];     assign ifc.rout = ctl[4];      assign ifc.baout = ctl[5];
    assign ifc.cout = ctl[6];       assign ifc.pcin = ctl[7];      assign ifc.irin = ctl[8];
    assign ifc.marin = ctl[9];      assign ifc.mdrin = ctl[10];    assign ifc.yin = ctl[11];
    assign ifc.zin = ctl[12];       assign ifc.rin = ctl[13];      assign ifc.conin = ctl[14];
    assign ifc.gra = ctl[15];       assign ifc.grb = ctl[16];      assign ifc.grc = ctl[17];
    assign ifc.mem_read = ctl[18];  assign ifc.mem_write = ctl[19]; assign ifc.op_inc = ctl[20];
    assign ifc.op_add = ctl[21];    assign ifc.op_sub = ctl[22];   assign ifc.op_and = ctl[23];
    assign ifc.op_or = ctl[24];     assign ifc.op_mul = ctl[25];   assign ifc.op_neg = ctl[26];
    assign ifc.op_not = ctl[27];    assign ifc.branch = ctl[28];

    always #5 clk = ~clk;

    typedef struct {
        int          op;
        logic [31:0] a, b;
        logic [63:0] z;
    } alu_vec_t;

    typedef struct {
        logic [3:0]  ra;
        logic [1:0]  cond;
        logic [31:0] rv, pc0;
        logic [18:0] c;
        logic        con;
        logic [31:0] pc;
    } br_vec_t;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [3:0] ra, input logic [3:0] rb, input logic [18:0] c);
        return {5'h12, ra, rb, c};
    endfunction

    function automatic logic [31:0] op_mask(input int op);
        logic [31:0] m [9] = '{INC, ADD, SUB, AND_, OR_, MUL, NEG, NOT_, 32'd0};
        return m[op];
    endfunction

    // Reference ALU from the operation definitions, using native integer arithmetic.
    function automatic logic [63:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        case (op)
            0: return {32'd0, b + 32'd1};
            1: return {32'd0, a + b};
            2: return {32'd0, a - b};
            3: return {32'd0, a & b};
            4: return {32'd0, a | b};
            5: return 64'(sa * sb);
            6: return {32'd0, 32'd0 - b};
            7: return {32'd0, ~b};
            default: return 64'd0;
        endcase
    endfunction

    task automatic step(input logic [31:0] s);
        ctl = s;
        @(posedge clk);
        #1;
        ctl = '0;
    endtask

    task automatic peek(input logic [31:0] s, output logic [31:0] v);
        ctl = s;
        #1;
        v = ifc.bus;
        ctl = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        mpc = 0;
    endtask

    task automatic fetch(input logic [31:0] instr);
        dut.mem[mpc[8:0]] <= instr;
        step(PCOUT | MARIN | INC | ZIN);
        step(ZLOWOUT | PCIN | READ | MDRIN);
        step(MDROUT | IRIN);
        mpc = mpc + 1;
    endtask

    task automatic load_reg(input logic [3:0] k, input logic [31:0] v);
        dut.mem[500] <= v;
        fetch(ins(k, 4'd0, 19'd500));
        step(COUT | MARIN);
        step(READ | MDRIN);
        step(MDROUT | GRA | RIN);
    endtask

    task automatic set_pc(input logic [31:0] v);
        fetch(ins(4'd0, 4'd0, v[18:0]));
        step(COUT | PCIN);
        mpc = v;
    endtask

    task automatic run_alu(input string n, input int op, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp);
        logic [31:0] lo, hi;
        do_reset();
        load_reg(4'd1, a);
        load_reg(4'd2, b);
        fetch(ins(4'd1, 4'd2, 19'd0));
        step(GRA | ROUT | YIN);
        step(GRB | ROUT | op_mask(op) | ZIN);
        peek(ZLOWOUT, lo);
        peek(ZHIGHOUT, hi);
        chk(n, {hi, lo}, exp);
    endtask

    task automatic run_branch(input string n, input br_vec_t v);
        logic [31:0] instr;
        do_reset();
        load_reg(v.ra, v.rv);
        set_pc(v.pc0);
        instr = ins(v.ra, {2'b00, v.cond}, v.c);
        fetch(instr);
        step(GRA | ROUT | CONIN);
        step(PCOUT | YIN);
        step(COUT | ADD | ZIN);
        step(ZLOWOUT | BRANCH);
        chk({n, "_ir"}, ifc.ir, instr);
        chk({n, "_con"}, ifc.con, v.con);
        chk({n, "_pc"}, ifc.pc, v.pc);
    endtask

    initial begin
        alu_vec_t    av [12];
        br_vec_t     bv [5];
        br_vec_t     rb;
        logic [31:0] v, a, b;
        int          op;

        av[0]  = '{1, 32'hFFFF_FFFF, 32'd1, 64'd0};
        av[1]  = '{5, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB};
        av[2]  = '{0, 32'd0, 32'd41, 64'd42};
        av[3]  = '{2, 32'd5, 32'd7, 64'h0000_0000_FFFF_FFFE};
        av[4]  = '{3, 32'hF0F0_1234, 32'h0FF0_FFFF, 64'h0000_0000_00F0_1234};
        av[5]  = '{4, 32'hF000_0000, 32'h0000_000F, 64'h0000_0000_F000_000F};
        av[6]  = '{6, 32'd0, 32'd5, 64'h0000_0000_FFFF_FFFB};
        av[7]  = '{7, 32'd0, 32'd0, 64'h0000_0000_FFFF_FFFF};
        av[8]  = '{8, 32'd5, 32'd7, 64'd0};
        av[9]  = '{5, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        av[10] = '{5, 32'h7FFF_FFFF, 32'd2, 64'h0000_0000_FFFF_FFFE};
        av[11] = '{0, 32'd0, 32'hFFFF_FFFF, 64'd0};

        bv[0] = '{4'd2, 2'b00, 32'd0, 32'd7, 19'd35, 1'b1, 32'd43};
        bv[1] = '{4'd2, 2'b01, 32'd0, 32'd7, 19'd35, 1'b0, 32'd8};
        bv[2] = '{4'd2, 2'b10, 32'd5, 32'd7, 19'd35, 1'b1, 32'd43};
        bv[3] = '{4'd2, 2'b11, 32'd5, 32'd7, 19'd35, 1'b0, 32'd8};
        bv[4] = '{4'd2, 2'b00, 32'd0, 32'd20, 19'h7FFFB, 1'b1, 32'd16};

        ctl = '0;
        mpc = 0;
        rst = 1'b1;
        #16;
        chk("por_pc", ifc.pc, 0);
        chk("por_ir", ifc.ir, 0);
        chk("por_con", ifc.con, 0);
        rst = 1'b0;

        // Register selection: BAout yields 0 for index 0 only.
        do_reset();
        load_reg(4'd0, 32'd123);
        peek(GRA | BAOUT, v);
        chk("baout_r0", v, 0);
        peek(GRA | ROUT, v);
        chk("rout_r0", v, 123);
        load_reg(4'd3, 32'd77);
        peek(GRA | BAOUT, v);
        chk("baout_r3", v, 77);

        // Memory write through MDR, then read back into a cleared MDR.
        fetch(ins(4'd3, 4'd0, 19'd450));
        step(COUT | MARIN);
        step(GRA | ROUT | MDRIN);
        step(WRITE);
        chk("mem_write", dut.mem[450], 77);
        step(MDRIN);
        step(READ | MDRIN);
        peek(MDROUT, v);
        chk("mem_read", v, 77);

        foreach (av[i]) run_alu($sformatf("alu_vec%0d", i), av[i].op, av[i].a, av[i].b, av[i].z);
        foreach (bv[i]) run_branch($sformatf("br_vec%0d", i), bv[i]);

        // Asynchronous reset in the middle of a fetch after a taken branch left state nonzero.
        run_branch("pre_reset", bv[0]);
        load_reg(4'd9, 32'hCAFE_F00D);
        ctl = PCOUT | MARIN | INC | ZIN;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_pc", ifc.pc, 0);
        chk("rst_ir", ifc.ir, 0);
        chk("rst_con", ifc.con, 0);
        chk("rst_z", dut.z_q, 0);
        for (int i = 0; i < 16; i++) chk($sformatf("rst_r%0d", i), dut.r_q[i], 0);
        rst = 1'b0;
        ctl = '0;
        mpc = 0;

        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 8));
            a = $urandom;
            b = $urandom;
            run_alu($sformatf("alu_rnd%0d", i), op, a, b, ref_alu(op, a, b));
        end

        for (int i = 0; i < 30; i++) begin
            rb.ra   = 4'($urandom_range(0, 15));
            rb.cond = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: rb.rv = 32'd0;
                1: rb.rv = $urandom & 32'h7FFF_FFFF;
                default: rb.rv = $urandom | 32'h8000_0000;
            endcase
            rb.pc0 = $urandom_range(2, 300);
            rb.c   = 19'($urandom);
            case (rb.cond)
                2'b00: rb.con = (rb.rv == 0);
                2'b01: rb.con = (rb.rv != 0);
                2'b10: rb.con = ($signed(rb.rv) >= 0);
                default: rb.con = ($signed(rb.rv) < 0);
            endcase
            rb.pc = rb.con ? rb.pc0 + 32'd1 + 32'(int'($signed(rb.c))) : rb.pc0 + 32'd1;
            run_branch($sformatf("br_rnd%0d", i), rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
